// File: rtl/controle_irrigacao_multizona_pkg.sv
// Shared types for the multi-zone irrigation controller: FSM state codes, tank level codes,
// default durations and the tank sensor decoder.
package controle_irrigacao_multizona_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StEnchendo = 3'd1,
        StGotej    = 3'd2,
        StAsper    = 3'd3,
        StLimpeza  = 3'd4,
        StErro     = 3'd5
    } estado_e;

    typedef enum logic [1:0] {
        NivelVazio,
        NivelBaixo,
        NivelMedio,
        NivelCheio
    } nivel_e;

    localparam int unsigned TGotejDef   = 30;
    localparam int unsigned TAsperDef   = 20;
    localparam int unsigned TLimpezaDef = 5;
    localparam int unsigned TFillMaxDef = 60;

    // Wet sensors must form a contiguous stack from the bottom; anything else is a fault.
    function automatic logic nivel_invalido(input logic h, input logic m, input logic l);
        return !({h, m, l} inside {3'b000, 3'b001, 3'b011, 3'b111});
    endfunction

    function automatic nivel_e decode_nivel(input logic h, input logic m, input logic l);
        case ({h, m, l})
            3'b001:  return NivelBaixo;
            3'b011:  return NivelMedio;
            3'b111:  return NivelCheio;
            default: return NivelVazio;
        endcase
    endfunction

endpackage

// File: rtl/controle_irrigacao_multizona_rr_arbiter.sv
// Round-robin zone arbiter: first requesting zone after the last served one, wrapping around.
module rr_arbiter_zonas #(
    parameter int unsigned N_ZONES = 4,
    parameter int unsigned ZW      = 2
) (
    input  logic [N_ZONES-1:0] req_i,
    input  logic [ZW-1:0]      last_i,
    output logic               grant_valid_o,
    output logic [ZW-1:0]      grant_idx_o
);

    int idx;

    // Scan farthest-first so the nearest requester after last_i overwrites the rest.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        idx           = 0;
        for (int k = int'(N_ZONES); k >= 1; k--) begin
            idx = (int'(last_i) + k) % int'(N_ZONES);
            if (req_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = ZW'(idx);
            end
        end
    end

endmodule

// File: rtl/controle_irrigacao_multizona.sv
// Multi-zone irrigation controller: tank level decoding, fill control and round-robin timed
// drip/sprinkler runs with a cleaning interval, all outputs registered.
module controle_irrigacao_multizona
    import controle_irrigacao_multizona_pkg::*;
#(
    parameter int unsigned N_ZONES    = 4,
    parameter int unsigned ZW         = 2,
    parameter int unsigned TIMER_W    = 8,
    parameter int unsigned T_GOTEJ    = TGotejDef,
    parameter int unsigned T_ASPER    = TAsperDef,
    parameter int unsigned T_LIMPEZA  = TLimpezaDef,
    parameter int unsigned T_FILL_MAX = TFillMaxDef
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               tick_i,
    input  logic               lvl_h_i,
    input  logic               lvl_m_i,
    input  logic               lvl_l_i,
    input  logic [N_ZONES-1:0] us_i,
    input  logic [N_ZONES-1:0] ua_i,
    input  logic [N_ZONES-1:0] t_i,
    input  logic [N_ZONES-1:0] en_zona_i,
    output logic               ve_o,
    output logic [N_ZONES-1:0] vs_o,
    output logic [N_ZONES-1:0] bs_o,
    output logic               erro_o,
    output logic               alarme_o,
    output logic [2:0]         estado_o,
    output logic [ZW-1:0]      zona_o,
    output logic [TIMER_W-1:0] tempo_rest_o
);

    estado_e              state_q;
    logic [TIMER_W-1:0]   timer_q;
    logic [ZW-1:0]        zona_q;
    logic                 timeout_q;
    logic                 ve_q, erro_q, alarme_q;
    logic [N_ZONES-1:0]   vs_q, bs_q;

    nivel_e               nivel;
    logic                 lvl_err;
    logic                 grant_valid;
    logic [ZW-1:0]        grant_idx;
    logic [N_ZONES-1:0]   grant_oh, zona_oh;
    logic [TIMER_W-1:0]   timer_dec;
    logic                 fim_tick;

    assign nivel     = decode_nivel(lvl_h_i, lvl_m_i, lvl_l_i);
    assign lvl_err   = nivel_invalido(lvl_h_i, lvl_m_i, lvl_l_i);
    assign grant_oh  = N_ZONES'(1) << grant_idx;
    assign zona_oh   = N_ZONES'(1) << zona_q;
    assign timer_dec = (timer_q != '0) ? timer_q - TIMER_W'(1) : '0;
    assign fim_tick  = tick_i && (timer_q == TIMER_W'(1));

    rr_arbiter_zonas #(
        .N_ZONES (N_ZONES),
        .ZW      (ZW)
    ) u_arbiter (
        .req_i         (us_i & en_zona_i),
        .last_i        (zona_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            zona_q    <= ZW'(N_ZONES - 1);
            timeout_q <= 1'b0;
            ve_q      <= 1'b0;
            vs_q      <= '0;
            bs_q      <= '0;
            erro_q    <= 1'b0;
            alarme_q  <= 1'b0;
        end else begin
            // Outputs default closed; each branch re-opens what its next state drives.
            ve_q     <= 1'b0;
            vs_q     <= '0;
            bs_q     <= '0;
            erro_q   <= 1'b0;
            alarme_q <= (nivel == NivelVazio);
            if (lvl_err) begin
                state_q  <= StErro;
                timer_q  <= '0;
                erro_q   <= 1'b1;
                alarme_q <= 1'b1;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (nivel == NivelVazio || nivel == NivelBaixo) begin
                            state_q <= StEnchendo;
                            timer_q <= TIMER_W'(T_FILL_MAX);
                            ve_q    <= 1'b1;
                        end else if (grant_valid) begin
                            zona_q <= grant_idx;
                            if (ua_i[grant_idx] && !t_i[grant_idx]) begin
                                state_q <= StAsper;
                                timer_q <= TIMER_W'(T_ASPER);
                                bs_q    <= grant_oh;
                            end else begin
                                state_q <= StGotej;
                                timer_q <= TIMER_W'(T_GOTEJ);
                                vs_q    <= grant_oh;
                            end
                        end
                    end
                    StEnchendo: begin
                        if (nivel == NivelCheio) begin
                            state_q <= StIdle;
                            timer_q <= '0;
                        end else if (fim_tick) begin
                            state_q   <= StErro;
                            timer_q   <= '0;
                            timeout_q <= 1'b1;
                            erro_q    <= 1'b1;
                            alarme_q  <= 1'b1;
                        end else begin
                            ve_q <= 1'b1;
                            if (tick_i) timer_q <= timer_dec;
                        end
                    end
                    StGotej, StAsper: begin
                        if (nivel == NivelVazio) begin
                            state_q <= StEnchendo;
                            timer_q <= TIMER_W'(T_FILL_MAX);
                            ve_q    <= 1'b1;
                        end else if (fim_tick || !us_i[zona_q]) begin
                            state_q <= StLimpeza;
                            timer_q <= TIMER_W'(T_LIMPEZA);
                        end else begin
                            if (state_q == StGotej) vs_q <= zona_oh;
                            else                    bs_q <= zona_oh;
                            if (tick_i) timer_q <= timer_dec;
                        end
                    end
                    StLimpeza: begin
                        if (fim_tick) begin
                            state_q <= StIdle;
                            timer_q <= '0;
                        end else if (tick_i) begin
                            timer_q <= timer_dec;
                        end
                    end
                    StErro: begin
                        // A fill timeout pins the controller here until reset.
                        if (!timeout_q) begin
                            state_q <= StIdle;
                        end else begin
                            erro_q   <= 1'b1;
                            alarme_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        timer_q <= '0;
                    end
                endcase
            end
        end
    end

    assign ve_o         = ve_q;
    assign vs_o         = vs_q;
    assign bs_o         = bs_q;
    assign erro_o       = erro_q;
    assign alarme_o     = alarme_q;
    assign estado_o     = state_q;
    assign zona_o       = zona_q;
    assign tempo_rest_o = timer_q;

endmodule

// File: tb/tb_controle_irrigacao_multizona.sv
// Bench for the multi-zone irrigation controller (8 zones): directed scenarios plus random
// stimulus, every cycle compared against a behavioural model of the controller rules.
module tb_controle_irrigacao_multizona;

    localparam int N  = 8;
    localparam int ZW = 3;

    localparam int S_IDLE = 0, S_ENCH = 1, S_GOT = 2, S_ASP = 3, S_LIMP = 4, S_ERRO = 5;

    logic          clk = 1'b0;
    logic          rst, tick, lh, lm, ll;
    logic [N-1:0]  us, ua, t, en;
    logic          ve, erro, alarme;
    logic [N-1:0]  vs, bs;
    logic [2:0]    estado;
    logic [ZW-1:0] zona;
    logic [7:0]    tempo;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int m_st, m_tmr, m_zona;
    bit m_to, m_alarme;

    always #5 clk = ~clk;

    controle_irrigacao_multizona #(
        .N_ZONES (N),
        .ZW      (ZW)
    ) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .tick_i       (tick),
        .lvl_h_i      (lh),
        .lvl_m_i      (lm),
        .lvl_l_i      (ll),
        .us_i         (us),
        .ua_i         (ua),
        .t_i          (t),
        .en_zona_i    (en),
        .ve_o         (ve),
        .vs_o         (vs),
        .bs_o         (bs),
        .erro_o       (erro),
        .alarme_o     (alarme),
        .estado_o     (estado),
        .zona_o       (zona),
        .tempo_rest_o (tempo)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Level = number of wet sensors, valid only if they are wet from the bottom up.
    task automatic model_update();
        int cnt, pat;
        bit bad;
        cnt = int'(ll) + int'(lm) + int'(lh);
        pat = (1 << cnt) - 1;
        bad = (int'({lh, lm, ll}) != pat);
        if (rst) begin
            m_st = S_IDLE; m_tmr = 0; m_zona = N - 1; m_to = 0; m_alarme = 0;
            return;
        end
        m_alarme = (cnt == 0);
        if (bad) begin
            m_st = S_ERRO; m_tmr = 0;
        end else begin
            case (m_st)
                S_IDLE: begin
                    if (cnt <= 1) begin
                        m_st = S_ENCH; m_tmr = 60;
                    end else begin
                        for (int k = 1; k <= N; k++) begin
                            int z;
                            z = (m_zona + k) % N;
                            if (us[z] && en[z]) begin
                                m_zona = z;
                                if (ua[z] && !t[z]) begin m_st = S_ASP; m_tmr = 20; end
                                else                begin m_st = S_GOT; m_tmr = 30; end
                                break;
                            end
                        end
                    end
                end
                S_ENCH: begin
                    if (cnt == 3) begin
                        m_st = S_IDLE; m_tmr = 0;
                    end else if (tick) begin
                        if (m_tmr == 1) begin m_to = 1; m_st = S_ERRO; m_tmr = 0; end
                        else if (m_tmr > 0) m_tmr--;
                    end
                end
                S_GOT, S_ASP: begin
                    if (cnt == 0) begin
                        m_st = S_ENCH; m_tmr = 60;
                    end else if ((tick && m_tmr == 1) || !us[m_zona]) begin
                        m_st = S_LIMP; m_tmr = 5;
                    end else if (tick && m_tmr > 0) begin
                        m_tmr--;
                    end
                end
                S_LIMP: begin
                    if (tick) begin
                        if (m_tmr == 1) begin m_st = S_IDLE; m_tmr = 0; end
                        else if (m_tmr > 0) m_tmr--;
                    end
                end
                default: begin
                    if (!m_to) m_st = S_IDLE;
                end
            endcase
        end
        if (m_st == S_ERRO) m_alarme = 1;
    endtask

    task automatic step();
        logic [N-1:0] oh;
        @(posedge clk);
        model_update();
        #1;
        oh = N'(1) << m_zona;
        check_eq("estado", 32'(estado), 32'(m_st));
        check_eq("tempo_rest", 32'(tempo), 32'(m_tmr));
        check_eq("zona", 32'(zona), 32'(m_zona));
        check_eq("ve", 32'(ve), 32'(m_st == S_ENCH));
        check_eq("vs", 32'(vs), (m_st == S_GOT) ? 32'(oh) : 32'd0);
        check_eq("bs", 32'(bs), (m_st == S_ASP) ? 32'(oh) : 32'd0);
        check_eq("erro", 32'(erro), 32'(m_st == S_ERRO));
        check_eq("alarme", 32'(alarme), 32'(m_alarme));
    endtask

    task automatic set_lvl(input bit h, input bit m, input bit l);
        lh = h; lm = m; ll = l;
    endtask

    initial begin
        rst = 1; tick = 0; set_lvl(0, 0, 0);
        us = '0; ua = '0; t = '0; en = '1;

        // Reset state
        step();
        rst = 0;
        check_eq("rst_zona", 32'(zona), 32'(N - 1));
        check_eq("rst_estado", 32'(estado), 32'(S_IDLE));

        // Low tank fills, full tank returns to idle
        set_lvl(0, 0, 1);
        step();
        check_eq("t1_enchendo", 32'(estado), 32'(S_ENCH));
        check_eq("t1_ve_on", 32'(ve), 32'd1);
        set_lvl(1, 1, 1);
        step();
        check_eq("t1_idle", 32'(estado), 32'(S_IDLE));
        check_eq("t1_ve_off", 32'(ve), 32'd0);

        // Sprinkler on zone 0, soil gets wet mid-run
        us = 8'h01; ua = 8'h01;
        step();
        check_eq("t3_bs", 32'(bs), 32'h01);
        tick = 1;
        repeat (7) step();
        check_eq("t3_tempo", 32'(tempo), 32'd13);
        us = '0;
        step();
        check_eq("t3_limpeza", 32'(estado), 32'(S_LIMP));
        check_eq("t3_tempo_limp", 32'(tempo), 32'd5);
        repeat (5) step();
        check_eq("t3_idle", 32'(estado), 32'(S_IDLE));

        // Reset in the middle of a sprinkler run
        tick = 0; us = 8'h01;
        step();
        check_eq("t6_asper", 32'(estado), 32'(S_ASP));
        rst = 1;
        step();
        rst = 0;
        check_eq("t6_idle", 32'(estado), 32'(S_IDLE));
        check_eq("t6_bs", 32'(bs), 32'd0);
        check_eq("t6_zona", 32'(zona), 32'(N - 1));

        // Round robin between zones 1 and 3 with full-length drip runs
        us = 8'b0000_1010; ua = '0;
        step();
        check_eq("t2_zona1", 32'(zona), 32'd1);
        check_eq("t2_vs1", 32'(vs), 32'h02);
        tick = 1;
        repeat (29) step();
        check_eq("t2_still_gotej", 32'(estado), 32'(S_GOT));
        step();
        check_eq("t2_limpeza", 32'(estado), 32'(S_LIMP));
        repeat (5) step();
        step();
        check_eq("t2_zona3", 32'(zona), 32'd3);
        check_eq("t2_vs3", 32'(vs), 32'h08);

        // Sensor inconsistency mid-run
        tick = 0;
        set_lvl(1, 0, 1);
        step();
        check_eq("t4_erro", 32'(erro), 32'd1);
        check_eq("t4_alarme", 32'(alarme), 32'd1);
        check_eq("t4_vs", 32'(vs), 32'd0);
        set_lvl(1, 1, 1);
        step();
        check_eq("t4_idle", 32'(estado), 32'(S_IDLE));

        // Fill timeout is sticky until reset
        rst = 1; step(); rst = 0;
        us = '0; set_lvl(0, 0, 1);
        step();
        tick = 1;
        repeat (59) step();
        check_eq("t5_tempo1", 32'(tempo), 32'd1);
        step();
        check_eq("t5_erro", 32'(estado), 32'(S_ERRO));
        tick = 0; set_lvl(1, 1, 1);
        repeat (3) step();
        check_eq("t5_sticky", 32'(estado), 32'(S_ERRO));
        rst = 1; step(); rst = 0;
        check_eq("t5_cleared", 32'(erro), 32'd0);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            tick = ($urandom_range(0, 2) == 0);
            rst  = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 39) == 0) begin
                int r;
                logic [2:0] bits;
                r = int'($urandom_range(0, 9));
                if      (r <= 4) set_lvl(1, 1, 1);
                else if (r == 5) set_lvl(0, 1, 1);
                else if (r == 6) set_lvl(0, 0, 1);
                else if (r == 7) set_lvl(0, 0, 0);
                else begin
                    bits = 3'($urandom);
                    set_lvl(bits[2], bits[1], bits[0]);
                end
            end
            if ($urandom_range(0, 24) == 0) us = N'($urandom);
            if ($urandom_range(0, 24) == 0) ua = N'($urandom);
            if ($urandom_range(0, 24) == 0) t  = N'($urandom);
            if ($urandom_range(0, 99) == 0) en = N'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
